fetch_pc_unit: RTL and testbench

//  Owns the architectural PC and the instruction fetch path; sits directly downstream of the PC-select control.

---
 rtl/fetch_pc_unit_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_pc_unit.sv | 168 ++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch-stage definitions: PC-select codes, the NOP encoding, FSM states and address helpers.
package fetch_pc_unit_pkg;

    localparam logic [1:0]  PC_SEL_PC4    = 2'b00;
    localparam logic [1:0]  PC_SEL_ALU    = 2'b01;
    localparam logic [1:0]  PC_SEL_PCIMM  = 2'b10;
    localparam logic [1:0]  PC_SEL_RS1IMM = 2'b11;

    localparam logic [31:0] INST_NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10
    } fetch_state_e;

    // Force an address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // True when an address does not sit on a word boundary.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, inst} pairs between IMEM and decode.
// Flush empties it in one cycle; push into a full FIFO is only taken together with a pop.
module fetch_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage, pointers and occupancy; flush discards everything buffered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the architectural PC, issues IMEM reads, buffers returned words
// for decode and discards wrong-path fetches when execute redirects the PC.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_2000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pc_sel,
    input  logic        pc_sel_valid,
    input  logic [31:0] alu_target,
    input  logic [31:0] jal_target,
    input  logic [31:0] jalr_target,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        redirect,
    output logic        misalign_err
);

    localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int               OCC_W     = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

    fetch_state_e     state_r;
    fetch_state_e     state_next_s;
    logic [31:0]      pc_r;
    logic             epoch_r;
    logic             inflight_r;
    logic [31:0]      req_pc_r;
    logic             req_epoch_r;
    logic             redirect_r;
    logic             misalign_r;

    logic             take_redirect_s;
    logic [31:0]      target_s;
    logic             req_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] count_s;
    logic [CNT_W-1:0] count_next_s;
    logic [OCC_W-1:0] occ_next_s;
    logic [63:0]      fifo_dout_s;

    // A non-sequential select from execute overrides everything else this cycle.
    assign take_redirect_s = pc_sel_valid && (pc_sel != PC_SEL_PC4);

    // Requests only go out in FETCH and never in a cycle that is being redirected.
    assign req_s  = (state_r == ST_FETCH) && !take_redirect_s;

    // Returning word is kept only if it belongs to the current path and no flush is happening.
    assign push_s = inflight_r && (req_epoch_r == epoch_r) && !take_redirect_s
                    && (!fifo_full_s || pop_s);
    assign pop_s  = !fifo_empty_s && inst_ready && !take_redirect_s;

    assign imem_addr    = pc_r;
    assign imem_req     = req_s;
    assign inst_valid   = !fifo_empty_s;
    assign inst_pc      = fifo_dout_s[63:32];
    assign inst_data    = fifo_dout_s[31:0];
    assign redirect     = redirect_r;
    assign misalign_err = misalign_r;

    // Redirect target selection; JALR drops bit 0 before alignment checking.
    always_comb begin
        target_s = alu_target;
        case (pc_sel)
            PC_SEL_ALU:    target_s = alu_target;
            PC_SEL_PCIMM:  target_s = jal_target;
            PC_SEL_RS1IMM: target_s = jalr_target & 32'hFFFF_FFFE;
            default:       target_s = alu_target;
        endcase
    end

    // Buffer occupancy after this edge, counting the request about to be issued.
    always_comb begin
        count_next_s = count_s;
        if (take_redirect_s) begin
            count_next_s = {CNT_W{1'b0}};
        end else begin
            count_next_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);
        end
        occ_next_s = {1'b0, count_next_s} + OCC_W'(req_s);
    end

    // Next FSM state: stall fetching once every buffer slot is claimed.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_BOOT: begin
                state_next_s = ST_FETCH;
            end
            ST_FETCH, ST_HOLD: begin
                if (take_redirect_s) begin
                    state_next_s = ST_FETCH;
                end else if (occ_next_s >= DEPTH_OCC) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            default: begin
                state_next_s = ST_BOOT;
            end
        endcase
    end

    // FSM state plus the registered redirect/misalign pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_BOOT;
            redirect_r <= 1'b0;
            misalign_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            redirect_r <= take_redirect_s;
            misalign_r <= take_redirect_s && is_misaligned(target_s);
        end
    end

    // PC, path epoch and in-flight request tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r        <= RESET_PC;
            epoch_r     <= 1'b0;
            inflight_r  <= 1'b0;
            req_pc_r    <= 32'h0000_0000;
            req_epoch_r <= 1'b0;
        end else begin
            inflight_r <= req_s;
            if (take_redirect_s) begin
                pc_r    <= word_align(target_s);
                epoch_r <= ~epoch_r;
            end else if (req_s) begin
                pc_r    <= pc_r + 32'd4;
            end
            if (req_s) begin
                req_pc_r    <= pc_r;
                req_epoch_r <= epoch_r;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .flush (take_redirect_s),
        .din   ({req_pc_r, imem_rdata}),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (count_s)
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios followed by random
// redirect/backpressure traffic, scored against an instruction-stream model.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pc_sel;
    logic        pc_sel_valid;
    logic [31:0] alu_target, jal_target, jalr_target;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data, inst_pc;
    logic        redirect, misalign_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] last_pop_pc;
    int          pops;
    int          idle;
    bit          seen_zero;
    logic        req_before;
    logic [31:0] addr_before;

    always #5 clk = ~clk;

    fetch_pc_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .pc_sel(pc_sel), .pc_sel_valid(pc_sel_valid),
        .alu_target(alu_target), .jal_target(jal_target), .jalr_target(jalr_target),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .redirect(redirect), .misalign_err(misalign_err)
    );

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One-cycle-latency IMEM; returns garbage when not read so stray pushes get noticed.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? imem_word(imem_addr) : $urandom;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Advance one clock, scoring the pop/redirect/stall behaviour of that cycle.
    task automatic tick();
        logic        redir;
        logic [31:0] tgt;
        logic        held;
        logic [31:0] hp, hd;
        redir = pc_sel_valid && (pc_sel != 2'b00);
        case (pc_sel)
            2'b01:   tgt = alu_target;
            2'b10:   tgt = jal_target;
            default: tgt = jalr_target & 32'hFFFF_FFFE;
        endcase
        held = 1'b0; hp = 32'h0; hd = 32'h0;
        req_before  = imem_req;
        addr_before = imem_addr;
        if (!redir && inst_valid && inst_ready) begin
            check("pop_pc", inst_pc, exp_pc);
            check("pop_data", inst_data, imem_word(exp_pc));
            if (exp_pc == 32'h0) seen_zero = 1'b1;
            last_pop_pc = exp_pc;
            exp_pc = exp_pc + 32'd4;
            pops++;
            idle = 0;
        end else if (!redir && inst_ready) begin
            idle++;
            if (idle > 8) check("starved", 32'(idle), 32'd8);
        end
        if (!redir && inst_valid && !inst_ready) begin
            held = 1'b1; hp = inst_pc; hd = inst_data;
        end
        if (redir) begin
            exp_pc = tgt & 32'hFFFF_FFFC;
            idle = 0;
        end
        @(posedge clk); #1;
        check("redirect", {31'b0, redirect}, {31'b0, redir});
        check("misalign", {31'b0, misalign_err}, {31'b0, redir && (tgt[1:0] != 2'b00)});
        if (held) begin
            check("hold_valid", {31'b0, inst_valid}, 32'd1);
            check("hold_pc", inst_pc, hp);
            check("hold_data", inst_data, hd);
        end
    endtask

    // Asynchronous reset mid-cycle, immediate clear check, release and first-valid latency.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        pc_sel = 2'b00; pc_sel_valid = 1'b0;
        #1;
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_redirect", {31'b0, redirect}, 32'd0);
        check("rst_misalign", {31'b0, misalign_err}, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_inst_data", inst_data, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_pc = RST_PC; idle = 0;
        tick(); check("lat1", {31'b0, inst_valid}, 32'd0);
        tick(); check("lat2", {31'b0, inst_valid}, 32'd0);
        tick(); check("lat3", {31'b0, inst_valid}, 32'd1);
        check("first_pc", inst_pc, RST_PC);
    endtask

    // Run until n more words are popped, bounded by limit cycles.
    task automatic run_pops(input int n, input int limit);
        int target;
        target = pops + n;
        for (int i = 0; i < limit && pops < target; i++) tick();
        check("pop_count", 32'(pops >= target), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pc_sel = 2'b00; pc_sel_valid = 1'b0;
        alu_target = 32'h0; jal_target = 32'h0; jalr_target = 32'h0;
        inst_ready = 1'b1; pops = 0; idle = 0; seen_zero = 1'b0;
        exp_pc = RST_PC; last_pop_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;

        // 1: reset, latency, sequential stream 0x2000,0x2004,0x2008.
        do_reset();
        run_pops(3, 20);
        check("t1_last", last_pop_pc, 32'h0000_2008);

        // 2: backpressure fills exactly two entries and stops requests.
        inst_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 6) check("hold_noreq", {31'b0, imem_req}, 32'd0);
        end
        check("t2_buffered", imem_addr, exp_pc + 32'd8);
        inst_ready = 1'b1;
        run_pops(4, 30);

        // 3: ALU redirect while the fetch of 0x2008 is in flight.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            tick();
            if (req_before && addr_before == 32'h0000_2008) break;
        end
        check("t3_inflight", addr_before, 32'h0000_2008);
        pc_sel = 2'b01; alu_target = 32'h0000_3000; pc_sel_valid = 1'b1;
        tick();
        pc_sel_valid = 1'b0;
        run_pops(1, 10);
        check("t3_target", last_pop_pc, 32'h0000_3000);

        // 4: misaligned JALR, then JAL.
        pc_sel = 2'b11; jalr_target = 32'h0000_4003; pc_sel_valid = 1'b1;
        tick();
        pc_sel_valid = 1'b0;
        check("t4_pc", imem_addr, 32'h0000_4000);
        tick();
        pc_sel = 2'b10; jal_target = 32'h0000_5000; pc_sel_valid = 1'b1;
        tick();
        pc_sel_valid = 1'b0;
        run_pops(1, 10);
        check("t4_jal", last_pop_pc, 32'h0000_5000);

        // 5: PC+4 select with valid set never redirects.
        pc_sel = 2'b00; pc_sel_valid = 1'b1;
        run_pops(4, 20);
        pc_sel_valid = 1'b0;

        // 6: wrap past the top of the address space, then reset with the buffer full.
        pc_sel = 2'b10; jal_target = 32'hFFFF_FFF0; pc_sel_valid = 1'b1;
        tick();
        pc_sel_valid = 1'b0;
        for (int i = 0; i < 40 && !seen_zero; i++) tick();
        check("t6_wrap", {31'b0, seen_zero}, 32'd1);
        inst_ready = 1'b0;
        repeat (10) tick();
        check("t6_full", {31'b0, inst_valid}, 32'd1);
        do_reset();
        inst_ready = 1'b1;
        run_pops(3, 20);

        // Random redirects, targets and backpressure.
        for (int i = 0; i < 400; i++) begin
            int r;
            inst_ready = ($urandom_range(3) != 0);
            r = $urandom_range(15);
            alu_target = $urandom; jal_target = $urandom; jalr_target = $urandom;
            if ($urandom_range(3) != 0) begin
                alu_target[1:0] = 2'b00; jal_target[1:0] = 2'b00; jalr_target[1:0] = 2'b00;
            end
            if (r == 0) begin
                pc_sel_valid = 1'b1; pc_sel = 2'($urandom_range(3, 1));
            end else if (r == 1) begin
                pc_sel_valid = 1'b1; pc_sel = 2'b00;
            end else begin
                pc_sel_valid = 1'b0; pc_sel = 2'($urandom_range(3));
            end
            tick();
        end
        pc_sel_valid = 1'b0;
        inst_ready = 1'b1;
        run_pops(2, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
